xy_mod_sequencer: RTL

- Upstream feeder and downstream collector for the 16-bit x % (x − y) register peripheral.
- Accepts operand pairs over a valid/ready stream into a small FIFO.
- For each pair it drives the peripheral's write/read bus: writes x to address 0, writes y to address 1, then reads address 2.
- Captures the peripheral's result and presents it on a valid/ready result stream. Handles the divide-by-zero case (x == y) locally, without touching the bus.

---
 rtl/xy_mod_sequencer_if.sv | 31 +++
 rtl/xy_mod_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/xy_mod_sequencer_if.sv
// rtl/xy_mod_sequencer_if.sv - operand, peripheral-bus and result signals of the x % (x - y) sequencer
//   in_valid/in_ready/in_x/in_y    : operand pair stream into the sequencer
//   d/addr/w/r/e/out               : peripheral register bus, out is the peripheral read data
//   res_valid/res_ready/res/err    : result stream out of the sequencer
//   master = sequencer side, slave = environment side (operand source, peripheral, result sink)
interface xy_mod_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_y;
    logic [15:0] d;
    logic [1:0]  addr;
    logic        w;
    logic        r;
    logic        e;
    logic [31:0] out;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res;
    logic        err;

    modport master (
        input  in_valid, in_x, in_y, out, res_ready,
        output in_ready, d, addr, w, r, e, res_valid, res, err
    );

    modport slave (
        output in_valid, in_x, in_y, out, res_ready,
        input  in_ready, d, addr, w, r, e, res_valid, res, err
    );
endinterface

// File: rtl/xy_mod_sequencer.sv
// rtl/xy_mod_sequencer.sv - feeds operand pairs to the x % (x - y) peripheral and collects results
//   clk : system clock, all state updates on the rising edge
//   rst : asynchronous active-high reset
//   bus : xy_mod_sequencer_if.master
//         operand stream in (in_valid/in_ready/in_x/in_y) buffered in a DEPTH-entry FIFO,
//         peripheral bus out (d/addr/w/r/e, read data on out),
//         result stream out (res_valid/res_ready/res/err)
module xy_mod_sequencer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input logic                 clk,
    input logic                 rst,
    xy_mod_sequencer_if.master  bus
);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    // ZERO gives the x == y path one bus-free cycle before DONE, so its
    // result appears two edges after the pair was pushed.
    typedef enum logic [2:0] {IDLE, ZERO, WR_X, WR_Y, RD, CAP, DONE} state_t;

    logic [15:0]   fifo_x [DEPTH];
    logic [15:0]   fifo_y [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;

    state_t        state;
    state_t        state_nxt;
    logic [15:0]   yr;
    logic [15:0]   yr_nxt;
    logic [15:0]   d_q;
    logic [15:0]   d_nxt;
    logic [1:0]    addr_q;
    logic [1:0]    addr_nxt;
    logic          w_q;
    logic          w_nxt;
    logic          r_q;
    logic          r_nxt;
    logic [15:0]   res_q;
    logic [15:0]   res_nxt;
    logic          err_q;
    logic          err_nxt;
    logic          vld_q;
    logic          vld_nxt;
    logic          e_q;

    // Upper half of the read data carries nothing the sequencer needs.
    logic [15:0]   unused_out_hi;
    assign unused_out_hi = bus.out[31:16];

    assign full         = (count == FULL_COUNT);
    assign empty        = (count == '0);
    assign bus.in_ready = ~rst & ~full;
    assign push         = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_x[wr_ptr] <= bus.in_x;
            fifo_y[wr_ptr] <= bus.in_y;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW + 1)'(1);
            else if (pop && !push) count <= count - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            yr     <= '0;
            d_q    <= '0;
            addr_q <= '0;
            w_q    <= 1'b0;
            r_q    <= 1'b0;
            res_q  <= '0;
            err_q  <= 1'b0;
            vld_q  <= 1'b0;
            e_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            yr     <= yr_nxt;
            d_q    <= d_nxt;
            addr_q <= addr_nxt;
            w_q    <= w_nxt;
            r_q    <= r_nxt;
            res_q  <= res_nxt;
            err_q  <= err_nxt;
            vld_q  <= vld_nxt;
            e_q    <= 1'b1;
        end
    end

    // Outputs are registered, so each branch sets the values the bus must
    // carry while in the state being entered.
    always_comb begin
        state_nxt = state;
        yr_nxt    = yr;
        d_nxt     = d_q;
        addr_nxt  = addr_q;
        w_nxt     = 1'b0;
        r_nxt     = 1'b0;
        res_nxt   = res_q;
        err_nxt   = err_q;
        vld_nxt   = 1'b0;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop    = 1'b1;
                    yr_nxt = fifo_y[rd_ptr];
                    if (fifo_x[rd_ptr] == fifo_y[rd_ptr]) begin
                        state_nxt = ZERO;
                    end else begin
                        state_nxt = WR_X;
                        w_nxt     = 1'b1;
                        addr_nxt  = 2'd0;
                        d_nxt     = fifo_x[rd_ptr];
                    end
                end
            end
            ZERO: begin
                state_nxt = DONE;
                res_nxt   = '0;
                err_nxt   = 1'b1;
                vld_nxt   = 1'b1;
            end
            WR_X: begin
                state_nxt = WR_Y;
                w_nxt     = 1'b1;
                addr_nxt  = 2'd1;
                d_nxt     = yr;
            end
            WR_Y: begin
                state_nxt = RD;
                r_nxt     = 1'b1;
                addr_nxt  = 2'd2;
            end
            RD: begin
                state_nxt = CAP;
            end
            CAP: begin
                // The peripheral registered its read data on the edge leaving RD.
                state_nxt = DONE;
                res_nxt   = bus.out[15:0];
                err_nxt   = 1'b0;
                vld_nxt   = 1'b1;
            end
            DONE: begin
                if (bus.res_ready) state_nxt = IDLE;
                else               vld_nxt   = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.d         = d_q;
    assign bus.addr      = addr_q;
    assign bus.w         = w_q;
    assign bus.r         = r_q;
    assign bus.e         = e_q;
    assign bus.res       = res_q;
    assign bus.err       = err_q;
    assign bus.res_valid = vld_q;
endmodule
